// File: rtl/uart_rx_sequencer.sv
// UART receive bit-timing sequencer: start detection, mid-bit sample strobes,
// parity/stop checking and a valid/ack handshake for the completed frame.
module uart_rx_sequencer #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter bit PARITY_EN    = 1'b0,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Rx_In,
    input  logic Enable,
    input  logic Data_Ack,
    output logic Shift_En,
    output logic Bit_Out,
    output logic Rx_Busy,
    output logic Rx_Flag,
    output logic Data_Valid,
    output logic Parity_Err,
    output logic Frame_Err,
    output logic Overrun
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] HALF     = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             acc_q, acc_d;
    logic             pbad_q, pbad_d;
    logic             sync1_q, rx_s_q;
    logic             shift_q, shift_d;
    logic             bit_q, bit_d;
    logic             dv_q, dv_d;
    logic             perr_q, perr_d;
    logic             ferr_q, ferr_d;
    logic             ovr_q, ovr_d;
    logic             sample;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            acc_q   <= 1'b0;
            pbad_q  <= 1'b0;
            shift_q <= 1'b0;
            bit_q   <= 1'b0;
            dv_q    <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sync1_q <= Rx_In;
            rx_s_q  <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            pbad_q  <= pbad_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            dv_q    <= dv_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign sample = (cnt_q == LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        pbad_d  = pbad_q;
        shift_d = 1'b0;
        bit_d   = bit_q;
        dv_d    = dv_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        ovr_d   = 1'b0;

        // A completion in the same cycle overrides the ack-driven clear below.
        if (Data_Ack && dv_q) begin
            dv_d = 1'b0;
        end

        if (!Enable && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (Enable && !rx_s_q) begin
                        state_d = S_START;
                        cnt_d   = '0;
                    end
                end
                S_START: begin
                    if (cnt_q == HALF) begin
                        cnt_d = '0;
                        if (!rx_s_q) begin
                            state_d = S_DATA;
                            idx_d   = '0;
                            acc_d   = 1'b0;
                            pbad_d  = 1'b0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (sample) begin
                        shift_d = 1'b1;
                        bit_d   = rx_s_q;
                        acc_d   = acc_q ^ rx_s_q;
                        cnt_d   = '0;
                        idx_d   = idx_q + 1'b1;
                        if (idx_q == LAST_IDX) begin
                            state_d = PARITY_EN ? S_PARITY : S_STOP;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (sample) begin
                        pbad_d  = ((acc_q ^ rx_s_q) != PARITY_ODD);
                        cnt_d   = '0;
                        state_d = S_STOP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (sample) begin
                        perr_d  = PARITY_EN ? pbad_q : 1'b0;
                        ferr_d  = !rx_s_q;
                        dv_d    = 1'b1;
                        ovr_d   = dv_q && !Data_Ack;
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign Shift_En   = shift_q;
    assign Bit_Out    = bit_q;
    assign Rx_Flag    = (state_q == S_IDLE);
    assign Rx_Busy    = (state_q != S_IDLE);
    assign Data_Valid = dv_q;
    assign Parity_Err = perr_q;
    assign Frame_Err  = ferr_q;
    assign Overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx_sequencer.sv
// Randomised bench for uart_rx_sequencer: an 8N1 instance and an 8E1 instance
// driven with serial frames and checked against a frame-level reference model.
module tb_uart_rx_sequencer;

    localparam int CPB0 = 16;
    localparam int CPB1 = 12;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [1:0] rx;
    logic [1:0] en;
    logic [1:0] ack;
    wire  [1:0] se, bo, busy, flag, dv, perr, ferr, ovr;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int nstr[2]   = '{0, 0};
    int ovr_hi[2] = '{0, 0};
    bit sbits[2][1024];
    int stime[2][1024];

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    uart_rx_sequencer #(.CLKS_PER_BIT(CPB0), .DATA_BITS(8), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_dut0 (
        .Clk(Clk), .Reset(Reset), .Rx_In(rx[0]), .Enable(en[0]), .Data_Ack(ack[0]),
        .Shift_En(se[0]), .Bit_Out(bo[0]), .Rx_Busy(busy[0]), .Rx_Flag(flag[0]),
        .Data_Valid(dv[0]), .Parity_Err(perr[0]), .Frame_Err(ferr[0]), .Overrun(ovr[0])
    );

    uart_rx_sequencer #(.CLKS_PER_BIT(CPB1), .DATA_BITS(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_dut1 (
        .Clk(Clk), .Reset(Reset), .Rx_In(rx[1]), .Enable(en[1]), .Data_Ack(ack[1]),
        .Shift_En(se[1]), .Bit_Out(bo[1]), .Rx_Busy(busy[1]), .Rx_Flag(flag[1]),
        .Data_Valid(dv[1]), .Parity_Err(perr[1]), .Frame_Err(ferr[1]), .Overrun(ovr[1])
    );

    // Strobe and overrun monitor
    always @(negedge Clk) begin
        for (int k = 0; k < 2; k++) begin
            if (se[k] === 1'b1) begin
                if (nstr[k] < 1024) begin
                    sbits[k][nstr[k]] = bo[k];
                    stime[k][nstr[k]] = cyc;
                end
                nstr[k] = nstr[k] + 1;
            end
            if (ovr[k] === 1'b1) ovr_hi[k] = ovr_hi[k] + 1;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int cpb(input int k);
        return (k == 0) ? CPB0 : CPB1;
    endfunction

    function automatic int half(input int k);
        return (cpb(k) - 1) / 2;
    endfunction

    // Reference: even parity on dut1 only; parity bit counts with the data ones
    function automatic int exp_perr(input int k, input logic [7:0] data, input bit pbit);
        if (k == 0) return 0;
        return ((^data) ^ pbit) ? 1 : 0;
    endfunction

    task automatic drive_bit(input int k, input bit v);
        @(posedge Clk);
        #1 rx[k] = v;
        repeat (cpb(k) - 1) @(posedge Clk);
    endtask

    task automatic send_frame(input int k, input logic [7:0] data, input bit pbit,
                              input bit stop, output int t0);
        @(posedge Clk);
        #1 rx[k] = 1'b0;
        t0 = cyc;
        repeat (cpb(k) - 1) @(posedge Clk);
        for (int i = 0; i < 8; i++) drive_bit(k, data[i]);
        if (k == 1) drive_bit(k, pbit);
        drive_bit(k, stop);
    endtask

    task automatic idle(input int k, input int n);
        @(posedge Clk);
        #1 rx[k] = 1'b1;
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic ack_pulse(input int k);
        @(posedge Clk);
        #1 ack[k] = 1'b1;
        @(posedge Clk);
        #1 ack[k] = 1'b0;
        chk("ack_clears_dv", dv[k], 0);
    endtask

    task automatic check_bits(input string tag, input int k, input logic [7:0] data,
                              input int t0, input int base, input int exp_n);
        int n;
        int lat;
        n = nstr[k] - base;
        chk({tag, "_nstrobes"}, n, exp_n);
        for (int i = 0; i < exp_n && i < n; i++) begin
            chk({tag, "_bit"}, sbits[k][base + i], data[i]);
            if (i == 0) begin
                lat = stime[k][base] - t0;
                chk({tag, "_first_lat_in_window"},
                    (lat >= half(k) + cpb(k) + 1 && lat <= half(k) + cpb(k) + 5) ? 1 : 0, 1);
            end else begin
                chk({tag, "_spacing"}, stime[k][base + i] - stime[k][base + i - 1], cpb(k));
            end
        end
    endtask

    task automatic full_frame(input string tag, input int k, input logic [7:0] data,
                              input bit pbit, input bit stop);
        int t0;
        int base;
        base = nstr[k];
        send_frame(k, data, pbit, stop, t0);
        idle(k, 4);
        check_bits(tag, k, data, t0, base, 8);
        chk({tag, "_dv"}, dv[k], 1);
        chk({tag, "_perr"}, perr[k], exp_perr(k, data, pbit));
        chk({tag, "_ferr"}, ferr[k], stop ? 0 : 1);
        chk({tag, "_flag"}, flag[k], 1);
        chk({tag, "_busy"}, busy[k], 0);
    endtask

    initial begin
        int t0, base, o0, seen, w;
        logic [7:0] d;
        bit pb, sb;
        bit pre_dv, pre_perr, pre_ferr;

        Reset = 1'b0;
        rx    = 2'b11;
        en    = 2'b11;
        ack   = 2'b00;
        repeat (3) @(posedge Clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_flag", flag[k], 1);
            chk("rst_busy", busy[k], 0);
            chk("rst_dv", dv[k], 0);
            chk("rst_shift", se[k], 0);
            chk("rst_bit", bo[k], 0);
            chk("rst_perr", perr[k], 0);
            chk("rst_ferr", ferr[k], 0);
            chk("rst_ovr", ovr[k], 0);
        end
        Reset = 1'b1;
        repeat (5) @(posedge Clk);

        // Short low glitch while idle
        for (int k = 0; k < 2; k++) begin
            base = nstr[k];
            @(posedge Clk);
            #1 rx[k] = 1'b0;
            repeat (4) @(posedge Clk);
            #1 rx[k] = 1'b1;
            repeat (30) @(posedge Clk);
            #1;
            chk("glitch_nstrobes", nstr[k] - base, 0);
            chk("glitch_dv", dv[k], 0);
            chk("glitch_flag", flag[k], 1);
        end

        full_frame("a5", 0, 8'hA5, 1'b0, 1'b1);
        ack_pulse(0);

        full_frame("par_bad", 1, 8'h07, 1'b0, 1'b1);
        ack_pulse(1);
        full_frame("par_good", 1, 8'h07, 1'b1, 1'b1);
        ack_pulse(1);

        full_frame("stop_low", 0, 8'h3C, 1'b0, 1'b0);
        ack_pulse(0);
        full_frame("after_ferr", 0, 8'($urandom), 1'b0, 1'b1);
        ack_pulse(0);

        // Back-to-back without ack
        o0 = ovr_hi[0];
        base = nstr[0];
        send_frame(0, 8'h5A, 1'b0, 1'b1, t0);
        check_bits("b2b_first", 0, 8'h5A, t0, base, 8);
        chk("b2b_first_no_ovr", ovr_hi[0] - o0, 0);
        base = nstr[0];
        send_frame(0, 8'hC3, 1'b0, 1'b1, t0);
        idle(0, 4);
        check_bits("b2b_second", 0, 8'hC3, t0, base, 8);
        chk("b2b_ovr_cycles", ovr_hi[0] - o0, 1);
        chk("b2b_dv", dv[0], 1);
        ack_pulse(0);

        // Back-to-back with ack landing on the completion cycle
        send_frame(0, 8'h96, 1'b0, 1'b1, t0);
        chk("coin_first_dv", dv[0], 1);
        o0 = ovr_hi[0];
        seen = 0;
        w = 0;
        fork
            send_frame(0, 8'h69, 1'b0, 1'b1, t0);
            begin
                while (seen < 8 && w < 4000) begin
                    @(negedge Clk);
                    w++;
                    if (se[0] === 1'b1) seen++;
                end
                if (seen == 8) begin
                    repeat (CPB0 - 1) @(posedge Clk);
                    #1 ack[0] = 1'b1;
                    @(posedge Clk);
                    #1 ack[0] = 1'b0;
                end
            end
        join
        idle(0, 4);
        chk("coin_strobes_seen", seen, 8);
        chk("coin_no_ovr", ovr_hi[0] - o0, 0);
        chk("coin_dv", dv[0], 1);

        // Enable dropped after the third strobe; dv left pending on purpose
        pre_dv = dv[0]; pre_perr = perr[0]; pre_ferr = ferr[0];
        base = nstr[0];
        seen = 0;
        w = 0;
        fork
            send_frame(0, 8'h00, 1'b0, 1'b1, t0);
            begin
                while (seen < 3 && w < 4000) begin
                    @(negedge Clk);
                    w++;
                    if (se[0] === 1'b1) seen++;
                end
                en[0] = 1'b0;
            end
        join
        idle(0, 4);
        chk("en_nstrobes", nstr[0] - base, 3);
        chk("en_flag", flag[0], 1);
        chk("en_dv_held", dv[0], pre_dv);
        chk("en_perr_held", perr[0], pre_perr);
        chk("en_ferr_held", ferr[0], pre_ferr);
        en[0] = 1'b1;
        ack_pulse(0);
        full_frame("after_en", 0, 8'($urandom), 1'b0, 1'b1);

        // Reset pulsed mid-data while dv is pending
        base = nstr[0];
        seen = 0;
        w = 0;
        fork
            send_frame(0, 8'hF8, 1'b0, 1'b1, t0);
            begin
                while (seen < 3 && w < 4000) begin
                    @(negedge Clk);
                    w++;
                    if (se[0] === 1'b1) seen++;
                end
                Reset = 1'b0;
                repeat (2) @(posedge Clk);
                #1;
                chk("rstmid_dv", dv[0], 0);
                chk("rstmid_flag", flag[0], 1);
                chk("rstmid_busy", busy[0], 0);
                chk("rstmid_shift", se[0], 0);
                chk("rstmid_ferr", ferr[0], 0);
                Reset = 1'b1;
            end
        join
        idle(0, 4);
        chk("rstmid_nstrobes", nstr[0] - base, 3);
        chk("rstmid_dv_after", dv[0], 0);
        full_frame("after_rst", 0, 8'($urandom), 1'b0, 1'b1);

        // Randomised frames on both instances
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < 2; k++) begin
                if (dv[k] === 1'b1) ack_pulse(k);
                d  = 8'($urandom);
                pb = 1'($urandom);
                sb = ($urandom_range(0, 3) != 0);
                full_frame("rand", k, d, pb, sb);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
